gmii_rx_framer: RTL and testbench

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

---
 rtl/gmii_rx_framer.sv | 181 ++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delays data by 4 bytes to drop the FCS,
// and reports frame completion. Optional CRC-32 FCS check enabled by `define FCS_CHECK_EN.
module gmii_rx_framer (
  input  logic        clk125MHz,
  input  logic        rst_n,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  input  logic [7:0]  gmii_rxd,
  output logic        rx_en,
  output logic [7:0]  rx_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [10:0] frame_len
);

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [10:0] LEN_MAX  = 11'h7FF;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] dly_q, dly_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [10:0]     len_q, len_d;
  logic            armed_q, armed_d;
  logic            rx_en_q, rx_en_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [10:0]     flen_q, flen_d;
  logic            fcs_good;

`ifdef FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Reflected register form of the 0xC704DD7B residue
  assign fcs_good = (crc_q == 32'hDEBB20E3);
`else
  assign fcs_good = 1'b1;
`endif

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // armed_q blocks a frame tail seen after reset from being mistaken for a new frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gmii_rxdv) begin
          if (!armed_q)                  state_d = DROP;
          else if (gmii_rxd == PRE_BYTE) state_d = PREAMBLE;
          else if (gmii_rxd == SFD_BYTE) state_d = DATA;
          else                           state_d = DROP;
        end
      end
      PREAMBLE: begin
        if (!gmii_rxdv)                state_d = IDLE;
        else if (gmii_rxer)            state_d = DROP;
        else if (gmii_rxd == SFD_BYTE) state_d = DATA;
        else if (gmii_rxd != PRE_BYTE) state_d = DROP;
      end
      DATA: begin
        if (!gmii_rxdv)     state_d = IDLE;
        else if (gmii_rxer) state_d = DROP;
      end
      DROP: begin
        if (!gmii_rxdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    armed_d   = armed_q | ~gmii_rxdv;
    rx_en_d   = 1'b0;
    rx_data_d = rx_data_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    flen_d    = flen_q;
`ifdef FCS_CHECK_EN
    crc_d     = crc_q;
`endif
    unique case (state_q)
      IDLE, PREAMBLE: begin
        cnt_d = '0;
        len_d = '0;
`ifdef FCS_CHECK_EN
        crc_d = '1;
`endif
      end
      DATA: begin
        if (gmii_rxdv && !gmii_rxer) begin
          dly_d = {dly_q[2:0], gmii_rxd};
`ifdef FCS_CHECK_EN
          crc_d = crc_byte(crc_q, gmii_rxd);
`endif
          if (cnt_q == 3'd4) begin
            rx_en_d   = 1'b1;
            rx_data_d = dly_q[3];
            if (len_q != LEN_MAX) len_d = len_q + 11'd1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (!gmii_rxdv) begin
          // Runt frames never delivered a byte, so len_q == 0 flags them
          ok_d   = (len_q != '0) && fcs_good;
          err_d  = !((len_q != '0) && fcs_good);
          flen_d = len_q;
          dly_d  = '0;
          cnt_d  = '0;
          len_d  = '0;
`ifdef FCS_CHECK_EN
          crc_d  = '1;
`endif
        end
      end
      DROP: begin
        if (!gmii_rxdv) begin
          err_d  = 1'b1;
          flen_d = len_q;
          dly_d  = '0;
          cnt_d  = '0;
          len_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      dly_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      armed_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      rx_data_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      flen_q    <= '0;
`ifdef FCS_CHECK_EN
      crc_q     <= '1;
`endif
    end else begin
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      armed_q   <= armed_d;
      rx_en_q   <= rx_en_d;
      rx_data_q <= rx_data_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      flen_q    <= flen_d;
`ifdef FCS_CHECK_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign rx_en     = rx_en_q;
  assign rx_data   = rx_data_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign frame_len = flen_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Scoreboard bench for gmii_rx_framer: expected bytes and frame results are queued
// as frames are driven and retired by a negedge monitor.
module tb_gmii_rx_framer;

  logic        clk125MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic        gmii_rxdv = 1'b0;
  logic        gmii_rxer = 1'b0;
  logic [7:0]  gmii_rxd  = 8'h00;
  logic        rx_en;
  logic [7:0]  rx_data;
  logic        frame_ok;
  logic        frame_err;
  logic [10:0] frame_len;

  gmii_rx_framer dut (
    .clk125MHz (clk125MHz),
    .rst_n     (rst_n),
    .gmii_rxdv (gmii_rxdv),
    .gmii_rxer (gmii_rxer),
    .gmii_rxd  (gmii_rxd),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .frame_len (frame_len)
  );

  always #4 clk125MHz = ~clk125MHz;

  typedef struct packed { logic ok; logic [10:0] len; } fr_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  fr_t        fr_q[$];
  logic [7:0] pay[$];
  time        t_mark, en_rise_t;
  int         en_run, last_run, en_total, ok_cnt;
  logic       en_prev;
  logic [7:0] last_data;

`ifdef FCS_CHECK_EN
  localparam bit FCS_CHK = 1'b1;
`else
  localparam bit FCS_CHK = 1'b0;
`endif

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  task automatic put(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk125MHz);
    gmii_rxdv = dv;
    gmii_rxer = er;
    gmii_rxd  = d;
  endtask

  task automatic monitor();
    fr_t        e;
    logic [7:0] eb;
    en_prev = 1'b0; en_run = 0; last_run = 0; en_total = 0; ok_cnt = 0; last_data = 8'h00;
    forever begin
      @(negedge clk125MHz);
      if (rx_en) begin
        tests++;
        if (!en_prev) en_rise_t = $time;
        en_run++; en_total++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL rx_byte: unexpected rx_en, rx_data=%h", rx_data);
        end else begin
          eb = exp_q.pop_front();
          if (rx_data !== eb) begin
            fails++; $display("FAIL rx_byte: got %h expected %h", rx_data, eb);
          end
        end
      end else begin
        if (en_run > 0) begin last_run = en_run; en_run = 0; end
        if (rst_n) begin
          tests++;
          if (rx_data !== last_data) begin
            fails++; $display("FAIL rx_hold: got %h expected %h", rx_data, last_data);
          end
        end
      end
      if (frame_ok && frame_err) begin
        tests++; fails++; $display("FAIL pulse_excl: frame_ok and frame_err both 1");
      end else if (frame_ok || frame_err) begin
        tests++;
        if (frame_ok) ok_cnt++;
        if (fr_q.size() == 0) begin
          fails++; $display("FAIL pulse: unexpected pulse ok=%b len=%0d", frame_ok, frame_len);
        end else begin
          e = fr_q.pop_front();
          if (frame_ok !== e.ok || frame_len !== e.len) begin
            fails++;
            $display("FAIL pulse: got ok=%b len=%0d expected ok=%b len=%0d",
                     frame_ok, frame_len, e.ok, e.len);
          end
        end
      end
      en_prev   = rx_en;
      last_data = rx_data;
    end
  endtask

  // Drives preamble, SFD and pay (+FCS) with expectations queued first.
  task automatic tx(input bit add_fcs, input int flip_idx, input int er_idx, input bit fcs_ok);
    logic [7:0]  fr[$];
    logic [31:0] c;
    int          n, del;
    fr = pay;
    if (add_fcs) begin
      c = crc32(fr);
      fr.push_back(c[7:0]);   fr.push_back(c[15:8]);
      fr.push_back(c[23:16]); fr.push_back(c[31:24]);
    end
    if (flip_idx >= 0) fr[flip_idx] = fr[flip_idx] ^ 8'h01;
    n = fr.size();
    if (er_idx >= 0) del = (er_idx > 4) ? er_idx - 4 : 0;
    else             del = (n > 4) ? n - 4 : 0;
    for (int i = 0; i < del; i++) exp_q.push_back(fr[i]);
    fr_q.push_back({(er_idx < 0) && (del > 0) && fcs_ok, (del > 2047) ? 11'd2047 : 11'(del)});
    repeat (7) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) begin
      put(1'b1, (i == er_idx), fr[i]);
      if (i == 0) t_mark = $time;
    end
    put(1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drain(input string name);
    repeat (10) put(1'b0, 1'b0, 8'h00);
    tests++;
    if (exp_q.size() != 0 || fr_q.size() != 0) begin
      fails++;
      $display("FAIL %s drain: %0d bytes / %0d pulses outstanding, expected 0/0",
               name, exp_q.size(), fr_q.size());
      exp_q.delete(); fr_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk125MHz);
    tests++;
    if ({rx_en, rx_data, frame_ok, frame_err, frame_len} !== 22'd0) begin
      fails++;
      $display("FAIL reset: got en=%b data=%h ok=%b err=%b len=%0d expected all 0",
               rx_en, rx_data, frame_ok, frame_err, frame_len);
    end
    rst_n = 1'b1;
    repeat (3) put(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_good_frame();
    fill(60);
    tx(1'b1, -1, -1, 1'b1);
    drain("good_frame");
    tests++;
    if (en_rise_t - t_mark != 40) begin
      fails++; $display("FAIL latency: got %0t expected 40", en_rise_t - t_mark);
    end
    tests++;
    if (last_run != 60) begin
      fails++; $display("FAIL good_run: got %0d expected 60", last_run);
    end
  endtask

  task automatic test_bad_fcs();
    fill(60);
    tx(1'b1, 10, -1, !FCS_CHK);
    drain("bad_fcs");
    tests++;
    if (last_run != 60) begin
      fails++; $display("FAIL bad_fcs_run: got %0d expected 60", last_run);
    end
  endtask

  task automatic test_rxer();
    fill(60);
    tx(1'b1, -1, 20, 1'b1);
    drain("rxer");
    tests++;
    if (last_run != 16) begin
      fails++; $display("FAIL rxer_run: got %0d expected 16", last_run);
    end
  endtask

  task automatic test_bad_preamble();
    int tot;
    tot = en_total;
    fr_q.push_back({1'b0, 11'd0});
    put(1'b1, 1'b0, 8'h55); put(1'b1, 1'b0, 8'h55); put(1'b1, 1'b0, 8'h12);
    repeat (4) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 10; i++) put(1'b1, 1'b0, 8'(i + 1));
    put(1'b0, 1'b0, 8'h00);
    drain("bad_preamble");
    tests++;
    if (en_total != tot) begin
      fails++; $display("FAIL bad_pre_en: got %0d rx_en cycles expected 0", en_total - tot);
    end
  endtask

  task automatic test_runt();
    fill(3); tx(1'b0, -1, -1, 1'b1); drain("runt3");
    fill(4); tx(1'b0, -1, -1, 1'b1); drain("runt4");
    fill(1); tx(1'b1, -1, -1, 1'b1); drain("min5");
  endtask

  task automatic test_back_to_back();
    int ok0;
    ok0 = ok_cnt;
    for (int f = 0; f < 80; f++) begin
      fill(30);
      pay[5] = 8'(f);
      tx(1'b1, -1, -1, 1'b1);
    end
    drain("back_to_back");
    tests++;
    if (ok_cnt - ok0 != 80) begin
      fails++; $display("FAIL b2b_ok: got %0d expected 80", ok_cnt - ok0);
    end
  endtask

  task automatic test_saturation();
    fill(2100);
    tx(1'b1, -1, -1, 1'b1);
    drain("saturation");
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  fr[$];
    logic [31:0] c;
    fill(60);
    fr = pay;
    c  = crc32(fr);
    fr.push_back(c[7:0]);   fr.push_back(c[15:8]);
    fr.push_back(c[23:16]); fr.push_back(c[31:24]);
    for (int i = 0; i < 26; i++) exp_q.push_back(fr[i]);
    fr_q.push_back({1'b0, 11'd0});
    repeat (7) put(1'b1, 1'b0, 8'h55);
    put(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 31; i++) put(1'b1, 1'b0, fr[i]);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({rx_en, rx_data, frame_ok, frame_err, frame_len} !== 22'd0) begin
      fails++;
      $display("FAIL async_reset: got en=%b data=%h ok=%b err=%b len=%0d expected all 0",
               rx_en, rx_data, frame_ok, frame_err, frame_len);
    end
    @(negedge clk125MHz);
    #1 rst_n = 1'b1;
    for (int i = 31; i < 64; i++) put(1'b1, 1'b0, fr[i]);
    put(1'b0, 1'b0, 8'h00);
    drain("reset_tail");
    tests++;
    if (last_run != 26) begin
      fails++; $display("FAIL reset_run: got %0d expected 26", last_run);
    end
    fill(60);
    tx(1'b1, -1, -1, 1'b1);
    drain("after_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_rxer();
    test_bad_preamble();
    test_runt();
    test_back_to_back();
    test_saturation();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
